// File: rtl/write_buffer_if.sv
// Generic request/response bus used on both sides of the write buffer.
// The master drives the request; the slave returns data and a one-cycle ready.
interface write_buffer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              strobe;
   logic              rw;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   modport master (output strobe, rw, address, wdata, input rdata, ready);
   modport slave  (input strobe, rw, address, wdata, output rdata, ready);
endinterface

// File: rtl/write_buffer.sv
// Posted write buffer for a write-through cache: writes queue in a FIFO and are
// drained to memory in order; reads forward from the buffer or bypass to memory.
module write_buffer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   write_buffer_if.slave              c,
   write_buffer_if.master             m,
   output logic                       wb_empty,
   output logic [$clog2(DEPTH+1)-1:0] wb_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, RD_RSP} state_t;
   state_t state, state_n;

   logic [ADDR_W-1:0] fifo_addr [DEPTH];
   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count, count_n;

   logic              req, busy_rd, hit, push, pop;
   logic [DATA_W-1:0] hit_data;

   logic              c_ready_q, c_ready_n;
   logic [DATA_W-1:0] c_rdata_q, c_rdata_n;
   logic              m_strobe_q, m_strobe_n;
   logic              m_rw_q, m_rw_n;
   logic [ADDR_W-1:0] m_address_q, m_address_n;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_n;
   logic              wb_empty_q, wb_empty_n;

   assign c.ready   = c_ready_q;
   assign c.rdata   = c_rdata_q;
   assign m.strobe  = m_strobe_q;
   assign m.rw      = m_rw_q;
   assign m.address = m_address_q;
   assign m.wdata   = m_wdata_q;
   assign wb_empty  = wb_empty_q;
   assign wb_count  = count;

   // Scan oldest to youngest so the last match is the most recent write.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (CNT_W'(k) < count && fifo_addr[rd_ptr + PTR_W'(k)] == c.address) begin
            hit      = 1'b1;
            hit_data = fifo_data[rd_ptr + PTR_W'(k)];
         end
      end
   end

   always_comb begin
      req         = c.strobe && !c_ready_q;
      busy_rd     = (state == RD_MEM) || (state == RD_RSP);
      state_n     = state;
      push        = 1'b0;
      pop         = 1'b0;
      c_ready_n   = 1'b0;
      c_rdata_n   = c_rdata_q;
      m_strobe_n  = m_strobe_q;
      m_rw_n      = m_rw_q;
      m_address_n = m_address_q;
      m_wdata_n   = m_wdata_q;

      if (req && !c.rw && count != CNT_W'(DEPTH)) begin
         push      = 1'b1;
         c_ready_n = 1'b1;
      end
      if (req && c.rw && hit && !busy_rd) begin
         c_ready_n = 1'b1;
         c_rdata_n = hit_data;
      end

      case (state)
         IDLE: begin
            if (req && c.rw && !hit) begin
               state_n     = RD_MEM;
               m_strobe_n  = 1'b1;
               m_rw_n      = 1'b1;
               m_address_n = c.address;
            end else if (count != '0) begin
               state_n     = WR_MEM;
               m_strobe_n  = 1'b1;
               m_rw_n      = 1'b0;
               m_address_n = fifo_addr[rd_ptr];
               m_wdata_n   = fifo_data[rd_ptr];
            end
         end
         WR_MEM: begin
            if (m.ready && m_strobe_q) begin
               pop        = 1'b1;
               m_strobe_n = 1'b0;
               state_n    = IDLE;
            end
         end
         RD_MEM: begin
            if (m.ready && m_strobe_q) begin
               m_strobe_n = 1'b0;
               c_rdata_n  = m.rdata;
               state_n    = RD_RSP;
            end
         end
         RD_RSP: begin
            c_ready_n = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase

      case ({push, pop})
         2'b10:   count_n = count + CNT_W'(1);
         2'b01:   count_n = count - CNT_W'(1);
         default: count_n = count;
      endcase
      // A write in flight still occupies the head, so count alone covers it.
      wb_empty_n = (count_n == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         c_ready_q   <= 1'b0;
         c_rdata_q   <= '0;
         m_strobe_q  <= 1'b0;
         m_rw_q      <= 1'b0;
         m_address_q <= '0;
         m_wdata_q   <= '0;
         wb_empty_q  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count       <= count_n;
         c_ready_q   <= c_ready_n;
         c_rdata_q   <= c_rdata_n;
         m_strobe_q  <= m_strobe_n;
         m_rw_q      <= m_rw_n;
         m_address_q <= m_address_n;
         m_wdata_q   <= m_wdata_n;
         wb_empty_q  <= wb_empty_n;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= c.address;
         fifo_data[wr_ptr] <= c.wdata;
      end
   end
endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: cache requests and memory responses are
// driven step by step and every observed output is checked against hand values.
module tb_write_buffer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wb_empty;
   logic [2:0] wb_count;
   int         checks = 0;
   int         passed = 0;
   logic       seen;
   logic [31:0] q_addr[$];
   logic [31:0] q_data[$];

   write_buffer_if #(.ADDR_W(32), .DATA_W(32)) c_bus ();
   write_buffer_if #(.ADDR_W(32), .DATA_W(32)) m_bus ();

   write_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .c        (c_bus),
      .m        (m_bus),
      .wb_empty (wb_empty),
      .wb_count (wb_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Present a cache request and hold it until c_ready (bounded).
   task automatic cache_req(input logic rw, input logic [31:0] a, input logic [31:0] d, input string tag);
      int n;
      c_bus.strobe = 1'b1;
      c_bus.rw = rw;
      c_bus.address = a;
      c_bus.wdata = d;
      n = 0;
      do begin
         tick();
         n++;
      end while (c_bus.ready !== 1'b1 && n < 20);
      chk(tag, c_bus.ready, 1);
      c_bus.strobe = 1'b0;
   endtask

   // Wait for a memory write, check it, and complete it with one m_ready pulse.
   task automatic serve(input logic [31:0] a, input logic [31:0] d, input string tag);
      for (int i = 0; i < 20 && m_bus.strobe !== 1'b1; i++) tick();
      chk({tag, "_stb"}, m_bus.strobe, 1);
      chk({tag, "_rw"}, m_bus.rw, 0);
      chk({tag, "_addr"}, m_bus.address, a);
      chk({tag, "_data"}, m_bus.wdata, d);
      m_bus.ready = 1'b1;
      tick();
      m_bus.ready = 1'b0;
   endtask

   initial begin
      c_bus.strobe = 1'b0;
      c_bus.rw = 1'b0;
      c_bus.address = '0;
      c_bus.wdata = '0;
      m_bus.ready = 1'b0;
      m_bus.rdata = '0;

      // Reset state and reset during WR_MEM
      tick();
      tick();
      chk("rst_cready", c_bus.ready, 0);
      chk("rst_mstrobe", m_bus.strobe, 0);
      chk("rst_crdata", c_bus.rdata, 0);
      chk("rst_maddr", m_bus.address, 0);
      chk("rst_count", wb_count, 0);
      chk("rst_empty", wb_empty, 1);
      rst = 1'b1;
      tick();
      cache_req(1'b0, 32'h40, 32'h1, "t1_acc");
      tick();
      chk("t1_wrmem", m_bus.strobe, 1);
      rst = 1'b0;
      #1;
      chk("t1_async_stb", m_bus.strobe, 0);
      chk("t1_async_cnt", wb_count, 0);
      chk("t1_async_emp", wb_empty, 1);
      chk("t1_async_rdy", c_bus.ready, 0);
      tick();
      rst = 1'b1;
      tick();
      chk("t1_after_stb", m_bus.strobe, 0);

      // Single write with delayed memory completion
      cache_req(1'b0, 32'h100, 32'hDEADBEEF, "t2_acc");
      chk("t2_count", wb_count, 1);
      chk("t2_empty", wb_empty, 0);
      tick();
      chk("t2_stb", m_bus.strobe, 1);
      chk("t2_rw", m_bus.rw, 0);
      chk("t2_addr", m_bus.address, 32'h100);
      chk("t2_data", m_bus.wdata, 32'hDEADBEEF);
      tick();
      tick();
      chk("t2_hold_addr", m_bus.address, 32'h100);
      m_bus.ready = 1'b1;
      tick();
      m_bus.ready = 1'b0;
      chk("t2_done_stb", m_bus.strobe, 0);
      chk("t2_done_cnt", wb_count, 0);
      chk("t2_done_emp", wb_empty, 1);

      // Fill to DEPTH, fifth write waits for a pop
      for (int i = 0; i < 4; i++) cache_req(1'b0, 32'h10 + i, 32'hA0 + i, "t3_acc");
      chk("t3_count", wb_count, 4);
      c_bus.strobe = 1'b1;
      c_bus.rw = 1'b0;
      c_bus.address = 32'h14;
      c_bus.wdata = 32'hA4;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (c_bus.ready === 1'b1) seen = 1'b1;
      end
      chk("t3_full_wait", seen, 0);
      chk("t3_head_addr", m_bus.address, 32'h10);
      m_bus.ready = 1'b1;
      tick();
      m_bus.ready = 1'b0;
      chk("t3_no_pass", c_bus.ready, 0);
      chk("t3_pop_cnt", wb_count, 3);
      tick();
      chk("t3_acc5", c_bus.ready, 1);
      chk("t3_cnt5", wb_count, 4);
      c_bus.strobe = 1'b0;
      for (int i = 1; i < 5; i++) serve(32'h10 + i, 32'hA0 + i, "t3_drain");
      chk("t3_empty", wb_empty, 1);

      // Read hit returns youngest matching entry
      cache_req(1'b0, 32'h200, 32'hA, "t4_wa");
      cache_req(1'b0, 32'h200, 32'hB, "t4_wb");
      cache_req(1'b1, 32'h200, 32'h0, "t4_rd");
      chk("t4_rdata", c_bus.rdata, 32'hB);
      chk("t4_mrw", m_bus.rw, 0);
      chk("t4_count", wb_count, 2);
      serve(32'h200, 32'hA, "t4_d0");
      serve(32'h200, 32'hB, "t4_d1");

      // Read miss waits for the in-flight write, then bypasses the queue
      cache_req(1'b0, 32'h310, 32'h1, "t5_w0");
      cache_req(1'b0, 32'h320, 32'h2, "t5_w1");
      c_bus.strobe = 1'b1;
      c_bus.rw = 1'b1;
      c_bus.address = 32'h300;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (c_bus.ready === 1'b1) seen = 1'b1;
      end
      chk("t5_rd_wait", seen, 0);
      chk("t5_wr_addr", m_bus.address, 32'h310);
      m_bus.ready = 1'b1;
      tick();
      m_bus.ready = 1'b0;
      chk("t5_gap", m_bus.strobe, 0);
      chk("t5_cnt", wb_count, 1);
      tick();
      chk("t5_rd_stb", m_bus.strobe, 1);
      chk("t5_rd_rw", m_bus.rw, 1);
      chk("t5_rd_addr", m_bus.address, 32'h300);
      m_bus.rdata = 32'h12345678;
      m_bus.ready = 1'b1;
      tick();
      m_bus.ready = 1'b0;
      m_bus.rdata = '0;
      chk("t5_rsp_wait", c_bus.ready, 0);
      tick();
      chk("t5_rdy", c_bus.ready, 1);
      chk("t5_rdata", c_bus.rdata, 32'h12345678);
      c_bus.strobe = 1'b0;
      serve(32'h320, 32'h2, "t5_d1");

      // Simultaneous push and pop at count=2
      cache_req(1'b0, 32'h600, 32'h60, "t6_f0");
      cache_req(1'b0, 32'h601, 32'h61, "t6_f1");
      q_addr.push_back(32'h600);
      q_data.push_back(32'h60);
      q_addr.push_back(32'h601);
      q_data.push_back(32'h61);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t6_stb", m_bus.strobe, 1);
         chk("t6_addr", m_bus.address, q_addr[0]);
         chk("t6_data", m_bus.wdata, q_data[0]);
         void'(q_addr.pop_front());
         void'(q_data.pop_front());
         q_addr.push_back(32'h602 + i);
         q_data.push_back(32'h62 + i);
         c_bus.strobe = 1'b1;
         c_bus.rw = 1'b0;
         c_bus.address = 32'h602 + i;
         c_bus.wdata = 32'h62 + i;
         m_bus.ready = 1'b1;
         tick();
         chk("t6_cnt", wb_count, 2);
         chk("t6_rdy", c_bus.ready, 1);
         c_bus.strobe = 1'b0;
         m_bus.ready = 1'b0;
         tick();
      end
      serve(q_addr[0], q_data[0], "t6_d0");
      serve(q_addr[1], q_data[1], "t6_d1");
      chk("t6_end_cnt", wb_count, 0);
      chk("t6_end_emp", wb_empty, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
